// File: rtl/easyaxi_pkg.sv
// Shared EasyAXI definitions: channel widths, burst/response encodings and
// the AR payload layout used by the slave-side queues.
package easyaxi_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_USER_W  = 4;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [AXI_BURST_W-1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2,
        AXI_BURST_RSVD  = 2'd3
    } axi_burst_e;

    typedef enum logic [AXI_RESP_W-1:0] {
        AXI_RESP_OKAY   = 2'd0,
        AXI_RESP_EXOKAY = 2'd1,
        AXI_RESP_SLVERR = 2'd2,
        AXI_RESP_DECERR = 2'd3
    } axi_resp_e;

    // AR payload, MSB first: {id, addr, len, size, burst, user}
    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
        logic [AXI_USER_W-1:0]  user;
    } axi_ar_t;

    localparam int AXI_AR_W = $bits(axi_ar_t);

endpackage

// File: rtl/easyaxi_slv_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Arithmetic wraps modulo 2^ADDR_W; the reserved burst type holds the address.
module easyaxi_slv_addr_gen
    import easyaxi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [ADDR_W-1:0]      next_addr
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wsize;
    logic [ADDR_W-1:0] wbase;

    // Next address per burst type; INCR realigns so only the first beat may be unaligned
    always_comb begin
        incr      = ADDR_W'(1) << size;
        wsize     = (ADDR_W'(len) + ADDR_W'(1)) << size;
        wbase     = addr & ~(wsize - ADDR_W'(1));
        next_addr = addr;
        case (burst)
            AXI_BURST_INCR: next_addr = (addr & ~(incr - ADDR_W'(1))) + incr;
            AXI_BURST_WRAP: next_addr = wbase | ((addr + incr) & (wsize - ADDR_W'(1)));
            default:        next_addr = addr;
        endcase
    end

endmodule

// File: rtl/easyaxi_slv_rd_ctrl.sv
// EasyAXI slave read controller: in-order AR queue feeding an R burst engine.
// Read data is the beat byte address, so a master can self-check the returns.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | no burst in flight; loads the queue head when one exists
// ST_BURST | rvalid high, beats advance on rready, head popped on rlast
module easyaxi_slv_rd_ctrl
    import easyaxi_pkg::*;
#(
    parameter int                ID_W       = AXI_ID_W,
    parameter int                ADDR_W     = AXI_ADDR_W,
    parameter int                DATA_W     = AXI_DATA_W,
    parameter int                USER_W     = AXI_USER_W,
    parameter int                OST_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0000_1000)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axi_slv_arvalid,
    output logic                   axi_slv_arready,
    input  logic [ID_W-1:0]        axi_slv_arid,
    input  logic [ADDR_W-1:0]      axi_slv_araddr,
    input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
    input  logic [USER_W-1:0]      axi_slv_aruser,
    output logic                   axi_slv_rvalid,
    input  logic                   axi_slv_rready,
    output logic [ID_W-1:0]        axi_slv_rid,
    output logic [DATA_W-1:0]      axi_slv_rdata,
    output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
    output logic                   axi_slv_rlast,
    output logic [USER_W-1:0]      axi_slv_ruser,
    output logic                   rd_busy
);

    localparam int PTR_W    = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int CNT_W    = $clog2(OST_DEPTH) + 1;
    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OST_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [ADDR_W-1:0]      addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
        logic [USER_W-1:0]      user;
    } ar_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Malformed requests still return len+1 beats, all flagged SLVERR
    function automatic logic req_slverr(input logic [AXI_LEN_W-1:0]   len,
                                        input logic [AXI_SIZE_W-1:0]  size,
                                        input logic [AXI_BURST_W-1:0] burst);
        logic bad_wrap_len;
        bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (burst == AXI_BURST_RSVD) ||
               (32'(size) > 32'(MAX_SIZE)) ||
               ((burst == AXI_BURST_WRAP) && bad_wrap_len);
    endfunction

    rd_state_e             state_q, state_d;
    ar_req_t               q_mem [OST_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, head_idx;
    logic [CNT_W-1:0]      q_cnt;
    ar_req_t               ar_in, head_req;

    logic [ID_W-1:0]        cur_id;
    logic [ADDR_W-1:0]      cur_addr;
    logic [AXI_LEN_W-1:0]   cur_len;
    logic [AXI_SIZE_W-1:0]  cur_size;
    logic [AXI_BURST_W-1:0] cur_burst;
    logic [USER_W-1:0]      cur_user;
    logic                   cur_slverr;
    logic [AXI_LEN_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]      next_addr;

    logic ar_hs, r_hs, last_hs, more_after_pop, load;

    assign ar_in = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                     size: axi_slv_arsize, burst: axi_slv_arburst, user: axi_slv_aruser};

    assign axi_slv_arready = (q_cnt != CNT_FULL);
    assign ar_hs           = axi_slv_arvalid & axi_slv_arready;
    assign r_hs            = (state_q == ST_BURST) & axi_slv_rready;
    assign last_hs         = r_hs & (beat_cnt == cur_len);
    // Only entries already stored can be chained without a bubble
    assign more_after_pop  = (q_cnt > CNT_W'(1));
    assign load            = ((state_q == ST_IDLE) && (q_cnt != '0)) || (last_hs && more_after_pop);
    assign head_idx        = last_hs ? ptr_inc(rd_ptr) : rd_ptr;
    assign head_req        = q_mem[head_idx];
    assign rd_busy         = (q_cnt != '0) | axi_slv_rvalid;

    easyaxi_slv_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (cur_addr),
        .len       (cur_len),
        .size      (cur_size),
        .burst     (cur_burst),
        .next_addr (next_addr)
    );

    // Queue storage: written on AR handshake, no reset needed
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            q_mem[wr_ptr] <= ar_in;
        end
    end

    // Queue pointers and occupancy; the head is popped on its last-beat handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (ar_hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (last_hs) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({ar_hs, last_hs})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (q_cnt != '0) state_d = ST_BURST;
            ST_BURST: if (last_hs && !more_after_pop) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Beat registers: load a request, or step beat count and address on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_id     <= '0;
            cur_addr   <= '0;
            cur_len    <= '0;
            cur_size   <= '0;
            cur_burst  <= '0;
            cur_user   <= '0;
            cur_slverr <= 1'b0;
            beat_cnt   <= '0;
        end else if (load) begin
            cur_id     <= head_req.id;
            cur_addr   <= head_req.addr;
            cur_len    <= head_req.len;
            cur_size   <= head_req.size;
            cur_burst  <= head_req.burst;
            cur_user   <= head_req.user;
            cur_slverr <= req_slverr(head_req.len, head_req.size, head_req.burst);
            beat_cnt   <= '0;
        end else if (r_hs) begin
            beat_cnt <= beat_cnt + AXI_LEN_W'(1);
            if (!cur_slverr) begin
                cur_addr <= next_addr;
            end
        end
    end

    // FSM outputs: R channel driven from the beat registers, SLVERR ahead of DECERR
    always_comb begin
        axi_slv_rvalid = (state_q == ST_BURST);
        axi_slv_rlast  = axi_slv_rvalid && (beat_cnt == cur_len);
        axi_slv_rid    = cur_id;
        axi_slv_ruser  = cur_user;
        axi_slv_rdata  = '0;
        axi_slv_rresp  = AXI_RESP_OKAY;
        if (axi_slv_rvalid) begin
            if (cur_slverr) begin
                axi_slv_rresp = AXI_RESP_SLVERR;
            end else if (cur_addr >= ADDR_LIMIT) begin
                axi_slv_rresp = AXI_RESP_DECERR;
            end else begin
                axi_slv_rdata = DATA_W'(cur_addr);
            end
        end
    end

endmodule

// File: tb/tb_easyaxi_slv_rd_ctrl.sv
// Directed bench for easyaxi_slv_rd_ctrl: bursts, queueing, stalls, errors, reset.
module tb_easyaxi_slv_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axi_slv_arvalid;
    logic        axi_slv_arready;
    logic [3:0]  axi_slv_arid;
    logic [31:0] axi_slv_araddr;
    logic [7:0]  axi_slv_arlen;
    logic [2:0]  axi_slv_arsize;
    logic [1:0]  axi_slv_arburst;
    logic [3:0]  axi_slv_aruser;
    logic        axi_slv_rvalid;
    logic        axi_slv_rready;
    logic [3:0]  axi_slv_rid;
    logic [31:0] axi_slv_rdata;
    logic [1:0]  axi_slv_rresp;
    logic        axi_slv_rlast;
    logic [3:0]  axi_slv_ruser;
    logic        rd_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_d [16];
    logic [1:0]  exp_r [16];

    easyaxi_slv_rd_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (axi_slv_arvalid),
        .axi_slv_arready (axi_slv_arready),
        .axi_slv_arid    (axi_slv_arid),
        .axi_slv_araddr  (axi_slv_araddr),
        .axi_slv_arlen   (axi_slv_arlen),
        .axi_slv_arsize  (axi_slv_arsize),
        .axi_slv_arburst (axi_slv_arburst),
        .axi_slv_aruser  (axi_slv_aruser),
        .axi_slv_rvalid  (axi_slv_rvalid),
        .axi_slv_rready  (axi_slv_rready),
        .axi_slv_rid     (axi_slv_rid),
        .axi_slv_rdata   (axi_slv_rdata),
        .axi_slv_rresp   (axi_slv_rresp),
        .axi_slv_rlast   (axi_slv_rlast),
        .axi_slv_ruser   (axi_slv_ruser),
        .rd_busy         (rd_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] user);
        int w;
        w = 0;
        axi_slv_arvalid = 1'b1;
        axi_slv_arid    = id;
        axi_slv_araddr  = addr;
        axi_slv_arlen   = len;
        axi_slv_arsize  = size;
        axi_slv_arburst = burst;
        axi_slv_aruser  = user;
        while (axi_slv_arready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("ar_accept", axi_slv_arready, 1);
        tick();
        axi_slv_arvalid = 1'b0;
    endtask

    // Expects n back-to-back beats matching exp_d/exp_r with rready held high
    task automatic expect_burst(input string tag, input logic [3:0] id, input logic [3:0] user, input int n);
        int w;
        w = 0;
        while (axi_slv_rvalid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_start"}, axi_slv_rvalid, 1);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, axi_slv_rvalid, 1);
            chk({tag, "_data"},  axi_slv_rdata, exp_d[i]);
            chk({tag, "_resp"},  axi_slv_rresp, exp_r[i]);
            chk({tag, "_id"},    axi_slv_rid, id);
            chk({tag, "_user"},  axi_slv_ruser, user);
            chk({tag, "_last"},  axi_slv_rlast, (i == n - 1) ? 1 : 0);
            tick();
        end
        chk({tag, "_end"}, axi_slv_rvalid, 0);
    endtask

    initial begin
        int hs, c, w;
        int pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
        logic [3:0] oid;

        rst_n           = 1'b0;
        axi_slv_arvalid = 1'b0;
        axi_slv_arid    = '0;
        axi_slv_araddr  = '0;
        axi_slv_arlen   = '0;
        axi_slv_arsize  = '0;
        axi_slv_arburst = '0;
        axi_slv_aruser  = '0;
        axi_slv_rready  = 1'b0;
        #2;
        chk("rst_arready", axi_slv_arready, 1);
        chk("rst_rvalid",  axi_slv_rvalid, 0);
        chk("rst_rlast",   axi_slv_rlast, 0);
        chk("rst_rid",     axi_slv_rid, 0);
        chk("rst_rdata",   axi_slv_rdata, 0);
        chk("rst_rresp",   axi_slv_rresp, 0);
        chk("rst_ruser",   axi_slv_ruser, 0);
        chk("rst_busy",    rd_busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // INCR with latency check
        axi_slv_rready = 1'b1;
        send_ar(4'd2, 32'h10, 8'd3, 3'd2, 2'd1, 4'd9);
        chk("incr_lat0", axi_slv_rvalid, 0);
        chk("incr_busy", rd_busy, 1);
        tick();
        chk("incr_lat1", axi_slv_rvalid, 1);
        exp_d[0] = 32'h10; exp_d[1] = 32'h14; exp_d[2] = 32'h18; exp_d[3] = 32'h1C;
        for (int i = 0; i < 4; i++) exp_r[i] = 2'd0;
        expect_burst("incr", 4'd2, 4'd9, 4);
        chk("incr_idle_busy", rd_busy, 0);

        // WRAP
        send_ar(4'd3, 32'h24, 8'd3, 3'd2, 2'd2, 4'd3);
        exp_d[0] = 32'h24; exp_d[1] = 32'h28; exp_d[2] = 32'h2C; exp_d[3] = 32'h20;
        expect_burst("wrap", 4'd3, 4'd3, 4);

        // FIXED
        send_ar(4'd4, 32'h30, 8'd3, 3'd2, 2'd0, 4'd4);
        for (int i = 0; i < 4; i++) exp_d[i] = 32'h30;
        expect_burst("fixed", 4'd4, 4'd4, 4);

        // Outstanding queue fill with rready low
        axi_slv_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_slv_arvalid = 1'b1;
            axi_slv_arid    = 4'(i);
            axi_slv_araddr  = 32'h100 + 32'(i) * 32'h10;
            axi_slv_arlen   = 8'd1;
            axi_slv_arsize  = 3'd2;
            axi_slv_arburst = 2'd1;
            axi_slv_aruser  = 4'(i);
            chk("ost_ardy", axi_slv_arready, 1);
            tick();
        end
        axi_slv_arid   = 4'd4;
        axi_slv_araddr = 32'h140;
        axi_slv_aruser = 4'd4;
        chk("ost_full", axi_slv_arready, 0);
        tick();
        chk("ost_full_hold", axi_slv_arready, 0);
        chk("ost_busy", rd_busy, 1);
        chk("ost_stall_valid", axi_slv_rvalid, 1);
        chk("ost_stall_id", axi_slv_rid, 0);
        axi_slv_rready = 1'b1;
        chk("ost_id0_b0", axi_slv_rdata, 32'h100);
        chk("ost_id0_b0_last", axi_slv_rlast, 0);
        tick();
        chk("ost_id0_b1", axi_slv_rdata, 32'h104);
        chk("ost_id0_b1_last", axi_slv_rlast, 1);
        chk("ost_id0_full", axi_slv_arready, 0);
        tick();
        chk("ost_ardy_after_pop", axi_slv_arready, 1);
        for (int k = 0; k < 8; k++) begin
            oid = 4'(1 + k / 2);
            chk("ost_valid", axi_slv_rvalid, 1);
            chk("ost_id",    axi_slv_rid, oid);
            chk("ost_data",  axi_slv_rdata, 32'h100 + 32'(oid) * 32'h10 + 32'(k % 2) * 32'h4);
            chk("ost_last",  axi_slv_rlast, k % 2);
            chk("ost_user",  axi_slv_ruser, oid);
            tick();
            if (k == 0) axi_slv_arvalid = 1'b0;
        end
        chk("ost_end_valid", axi_slv_rvalid, 0);
        chk("ost_end_busy", rd_busy, 0);

        // Backpressure on INCR len=7
        send_ar(4'd5, 32'h200, 8'd7, 3'd2, 2'd1, 4'd5);
        axi_slv_rready = 1'b0;
        w = 0;
        while (axi_slv_rvalid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        hs = 0;
        c  = 0;
        while (hs < 8 && c < 60) begin
            axi_slv_rready = pat[c % 12][0];
            chk("bp_valid", axi_slv_rvalid, 1);
            chk("bp_data",  axi_slv_rdata, 32'h200 + 32'(hs) * 32'h4);
            chk("bp_id",    axi_slv_rid, 5);
            chk("bp_last",  axi_slv_rlast, (hs == 7) ? 1 : 0);
            if (axi_slv_rready) hs++;
            tick();
            c++;
        end
        chk("bp_handshakes", hs, 8);
        chk("bp_end_valid", axi_slv_rvalid, 0);
        axi_slv_rready = 1'b1;

        // WRAP with illegal length -> SLVERR
        send_ar(4'd6, 32'h40, 8'd2, 3'd2, 2'd2, 4'd6);
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 32'h0;
            exp_r[i] = 2'd2;
        end
        expect_burst("wrap_len_err", 4'd6, 4'd6, 3);

        // Oversized beat -> SLVERR
        send_ar(4'd7, 32'h50, 8'd1, 3'd3, 2'd1, 4'd7);
        expect_burst("size_err", 4'd7, 4'd7, 2);

        // Reserved burst type -> SLVERR
        send_ar(4'd8, 32'h60, 8'd0, 3'd2, 2'd3, 4'd8);
        expect_burst("rsvd_err", 4'd8, 4'd8, 1);

        // Crossing the decode limit
        send_ar(4'd9, 32'hFF8, 8'd3, 3'd2, 2'd1, 4'd1);
        exp_d[0] = 32'hFF8; exp_d[1] = 32'hFFC; exp_d[2] = 32'h0; exp_d[3] = 32'h0;
        exp_r[0] = 2'd0;    exp_r[1] = 2'd0;    exp_r[2] = 2'd3;  exp_r[3] = 2'd3;
        expect_burst("decerr", 4'd9, 4'd1, 4);

        // Reset mid-burst
        send_ar(4'd10, 32'h300, 8'd3, 3'd2, 2'd1, 4'd2);
        w = 0;
        while (axi_slv_rvalid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        tick();
        chk("rst_mid_beat2", axi_slv_rdata, 32'h308);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid",  axi_slv_rvalid, 0);
        chk("rst_mid_arready", axi_slv_arready, 1);
        chk("rst_mid_busy",    rd_busy, 0);
        chk("rst_mid_rlast",   axi_slv_rlast, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rst_post_rvalid", axi_slv_rvalid, 0);
        send_ar(4'd11, 32'h400, 8'd1, 3'd2, 2'd1, 4'd3);
        exp_d[0] = 32'h400; exp_d[1] = 32'h404;
        exp_r[0] = 2'd0;    exp_r[1] = 2'd0;
        expect_burst("post_rst", 4'd11, 4'd3, 2);
        chk("post_rst_busy", rd_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
